accumulator_alu: RTL and testbench
==================================

# accumulator_alu

Parametrised multi-cycle arithmetic unit for the accumulator datapath. It combines the accumulator operand with a memory operand using add, subtract, add-with-carry or subtract-with-borrow. The operation is computed serially, DIGIT bits per clock, so wide datapaths reuse one narrow adder slice. It sits between the AC register and the memory read bus, returns result and flags to the control unit through a start/done handshake, and keeps a persistent carry flag for multi-word arithmetic.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per compute cycle; must divide WIDTH exactly.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state at the next rising edge.
- start  in  1  request; sampled only while the block is not busy.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC; sampled with start.
- AC  in  WIDTH  accumulator operand; sampled with start.
- Memory  in  WIDTH  memory operand; sampled with start.
- result  out  WIDTH  registered sum or difference.
- Cout  out  1  persistent carry flag (for SUB/SBC: 1 = no borrow).
- Zero  out  1  result == 0.
- Overflow  out  1  two's-complement signed overflow.
- busy  out  1  a computation is in progress.
- done  out  1  one-cycle pulse; result and flags are valid and just updated.

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- IDLE or DONE with start=1: latch AC into A and Memory into B. For SUB and SBC, B is inverted. Latch carry-in:
  - ADD: 0.
  - SUB: 1.
  - ADC and SBC: the current Cout.
  - Clear the digit counter and go to CALC.
- CALC: each cycle, add the low DIGIT bits of A and B plus the running carry. Shift the DIGIT-bit sum into the top of a partial-result register. Shift A and B right by DIGIT. Increment the counter.
- After WIDTH/DIGIT compute cycles, write result, Cout, Zero and Overflow in the same edge, then go to DONE.
- Overflow = (A_msb == B_msb) && (sum_msb != A_msb), where B_msb is the MSB after any inversion.
- DONE lasts one cycle and returns to IDLE unless start=1, which is accepted as from IDLE.
- start in CALC is ignored. There is no queueing.
- result and all flags hold their values between completions. They do not change during CALC; intermediate sums are never visible.
- Carry-out beyond bit WIDTH-1 goes only to Cout. result wraps modulo 2^WIDTH.
- A reset asserted mid-operation aborts the computation and returns to IDLE. result, flags, busy and done are all 0 at the next edge, with no done pulse.

## Timing
- Reset values: result=0, Cout=0, Zero=0, Overflow=0, busy=0, done=0, state IDLE.
- Start sampled at edge E: busy=1 from after E through edge E+N, where N = WIDTH/DIGIT.
- After edge E+N: busy=0, done=1, result and flags updated.
- After edge E+N+1: done=0, unless a new start was accepted at E+N+1. A start accepted there raises busy again.
- Latency is N+1 cycles from the start cycle to done. Back-to-back throughput is one operation per N+1 cycles.
- Defaults (WIDTH=8, DIGIT=2): N=4. DIGIT=WIDTH gives single-cycle compute, with done one cycle after start.
- ADC and SBC use the Cout value present in the cycle start is sampled.

## Test plan
- ADD, AC=0x95, Memory=0x8A -> done 4 cycles after start: result=0x1F, Cout=1, Overflow=1, Zero=0. busy high for exactly 4 cycles.
- ADD 0x49+0x1A -> result 0x63, Cout=0, Overflow=0. Then ADD 0xAA+0xB5 issued on the DONE cycle -> accepted back-to-back, result 0x5F, Cout=1, Overflow=1.
- SUB 0x49-0x49 -> result 0x00, Zero=1, Cout=1 (no borrow), Overflow=0. SUB 0x00-0x01 -> result 0xFF, Cout=0.
- Carry chaining:
  - ADD 0xFF+0x01 (Cout=1), then ADC 0x01+0x01 -> result 0x03.
  - SUB 0x00-0x01 (Cout=0), then SBC 0x10-0x01 -> result 0x0E, Cout=1.
- Protocol:
  - start pulsed during CALC -> ignored; the in-flight result is unchanged and only one done pulse occurs.
  - reset raised at the second CALC cycle -> all outputs 0 next edge, no done, next start behaves as from reset.
- Parameter sweep: WIDTH=16 with DIGIT=1, 4 and 16; random operands and ops against a reference model -> result and flags match, done exactly N cycles after start.

Source files
------------

// File: rtl/accumulator_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_alu_if
// Brief    : Start/done request bus between control unit and accumulator ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface accumulator_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] AC;
    logic [WIDTH-1:0] Memory;
    logic [WIDTH-1:0] result;
    logic             Cout;
    logic             Zero;
    logic             Overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, op, AC, Memory,
        input  result, Cout, Zero, Overflow, busy, done
    );

    modport slave (
        input  start, op, AC, Memory,
        output result, Cout, Zero, Overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/accumulator_alu.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_alu
// Brief    : Digit-serial ADD/SUB/ADC/SBC unit with persistent carry flag.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_alu #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    accumulator_alu_if.slave bus
);
    localparam int c_NUM_DIGITS = WIDTH / DIGIT;
    localparam int c_CNT_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_partial;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_cout;
    logic               r_zero;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;

    logic [DIGIT:0]     w_sum;
    logic [WIDTH-1:0]   w_partial_next;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_accept;
    logic               w_last;
    logic               w_cin;

    assign w_accept = bus.start && (r_state != S_CALC);
    assign w_last   = (r_cnt == c_LAST);
    assign w_b_in   = bus.op[0] ? ~bus.Memory : bus.Memory;
    // ADC/SBC chain the stored flag; plain ADD/SUB force 0/1.
    assign w_cin    = bus.op[1] ? r_cout : bus.op[0];
    assign w_sum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry};

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_partial_next = w_sum[DIGIT-1:0];
        end else begin : g_serial
            assign w_partial_next = {w_sum[DIGIT-1:0], r_partial[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_a       <= bus.AC;
            r_b       <= w_b_in;
            r_carry   <= w_cin;
            r_a_msb   <= bus.AC[WIDTH-1];
            r_b_msb   <= w_b_in[WIDTH-1];
            r_partial <= '0;
            r_cnt     <= '0;
        end else if (r_state == S_CALC) begin
            r_a       <= r_a >> DIGIT;
            r_b       <= r_b >> DIGIT;
            r_carry   <= w_sum[DIGIT];
            r_partial <= w_partial_next;
            r_cnt     <= r_cnt + c_CNT_W'(1);
            // Visible outputs only move on the final digit.
            if (w_last) begin
                r_result <= w_partial_next;
                r_cout   <= w_sum[DIGIT];
                r_zero   <= (w_partial_next == '0);
                r_ovf    <= (r_a_msb == r_b_msb) && (w_partial_next[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign bus.result   = r_result;
    assign bus.Cout     = r_cout;
    assign bus.Zero     = r_zero;
    assign bus.Overflow = r_ovf;
    assign bus.busy     = (r_state == S_CALC);
    assign bus.done     = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_accumulator_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_alu
// Brief    : Self-checking bench for accumulator_alu, default and 16-bit sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_alu;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    accumulator_alu_if #(.WIDTH(8)) bus8 ();
    accumulator_alu #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    accumulator_alu_if #(.WIDTH(16)) bus_d1 ();
    accumulator_alu_if #(.WIDTH(16)) bus_d4 ();
    accumulator_alu_if #(.WIDTH(16)) bus_d16 ();
    accumulator_alu #(.WIDTH(16), .DIGIT(1))  dut_d1  (.clk(clk), .reset(reset), .bus(bus_d1));
    accumulator_alu #(.WIDTH(16), .DIGIT(4))  dut_d4  (.clk(clk), .reset(reset), .bus(bus_d4));
    accumulator_alu #(.WIDTH(16), .DIGIT(16)) dut_d16 (.clk(clk), .reset(reset), .bus(bus_d16));

    logic        sw_start;
    logic [1:0]  sw_op;
    logic [15:0] sw_ac;
    logic [15:0] sw_mem;
    assign bus_d1.start  = sw_start;  assign bus_d1.op  = sw_op;
    assign bus_d1.AC     = sw_ac;     assign bus_d1.Memory  = sw_mem;
    assign bus_d4.start  = sw_start;  assign bus_d4.op  = sw_op;
    assign bus_d4.AC     = sw_ac;     assign bus_d4.Memory  = sw_mem;
    assign bus_d16.start = sw_start;  assign bus_d16.op = sw_op;
    assign bus_d16.AC    = sw_ac;     assign bus_d16.Memory = sw_mem;

    logic [2:0]  sw_done;
    logic [18:0] sw_out [3];
    assign sw_done   = {bus_d16.done, bus_d4.done, bus_d1.done};
    assign sw_out[0] = {bus_d1.Cout,  bus_d1.Zero,  bus_d1.Overflow,  bus_d1.result};
    assign sw_out[1] = {bus_d4.Cout,  bus_d4.Zero,  bus_d4.Overflow,  bus_d4.result};
    assign sw_out[2] = {bus_d16.Cout, bus_d16.Zero, bus_d16.Overflow, bus_d16.result};

    // Reference: plain integer add of A, (possibly inverted) B and carry-in;
    // overflow from the true signed sum leaving the representable range.
    function automatic void ref_op(input int w, input int a, input int m, input int op,
                                   input int cprev, output int res, output int cout,
                                   output int zero, output int ovf);
        int mask, half, b, cin, full, sa, sb, ss;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        b    = (op & 1) ? (~m & mask) : (m & mask);
        cin  = (op & 2) ? cprev : (op & 1);
        full = (a & mask) + b + cin;
        res  = full & mask;
        cout = (full >> w) & 1;
        zero = (res == 0) ? 1 : 0;
        sa   = ((a & mask) >= half) ? (a & mask) - 2 * half : (a & mask);
        sb   = (b >= half) ? b - 2 * half : b;
        ss   = sa + sb + cin;
        ovf  = (ss >= half || ss < -half) ? 1 : 0;
    endfunction

    task automatic run8(input int op, input int a, input int m, output int lat, output int bc);
        bus8.op     = 2'(op);
        bus8.AC     = 8'(a);
        bus8.Memory = 8'(m);
        bus8.start  = 1'b1;
        @(posedge clk); #1;
        bus8.start  = 1'b0;
        lat = 0;
        bc  = 0;
        while (1) begin
            if (bus8.busy) bc++;
            if (bus8.done || lat >= 40) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== 13'h0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0",
                     {bus8.busy, bus8.done, bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat, bc;
        run8(0, 'h95, 'h8A, lat, bc);
        total++;
        if (lat !== 4 || bc !== 4) begin
            bad++; $display("FAIL add_timing lat=%0d busy=%0d exp=4/4", lat, bc);
        end
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b101, 8'h1F}) begin
            bad++; $display("FAIL add_value got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b101, 8'h1F});
        end
        @(posedge clk); #1;
        total++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.result !== 8'h1F) begin
            bad++; $display("FAIL done_pulse done=%b busy=%b result=%h exp 0/0/1f",
                            bus8.done, bus8.busy, bus8.result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run8(0, 'h49, 'h1A, lat, bc);
        total++;
        if (lat !== 4 || {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b000, 8'h63}) begin
            bad++; $display("FAIL b2b_first lat=%0d got=%h exp=%h", lat,
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b000, 8'h63});
        end
        run8(0, 'hAA, 'hB5, lat, bc);
        total++;
        if (lat !== 4 || bc !== 4) begin
            bad++; $display("FAIL b2b_timing lat=%0d busy=%0d exp=4/4", lat, bc);
        end
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b101, 8'h5F}) begin
            bad++; $display("FAIL b2b_second got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b101, 8'h5F});
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        run8(1, 'h49, 'h49, lat, bc);
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b110, 8'h00}) begin
            bad++; $display("FAIL sub_equal got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b110, 8'h00});
        end
        run8(1, 'h00, 'h01, lat, bc);
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b000, 8'hFF}) begin
            bad++; $display("FAIL sub_borrow got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b000, 8'hFF});
        end
    endtask

    task automatic test_carry_chain();
        int lat, bc;
        run8(0, 'hFF, 'h01, lat, bc);
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b110, 8'h00}) begin
            bad++; $display("FAIL chain_add got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b110, 8'h00});
        end
        run8(2, 'h01, 'h01, lat, bc);
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b000, 8'h03}) begin
            bad++; $display("FAIL chain_adc got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b000, 8'h03});
        end
        run8(1, 'h00, 'h01, lat, bc);
        run8(3, 'h10, 'h01, lat, bc);
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b100, 8'h0E}) begin
            bad++; $display("FAIL chain_sbc got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b100, 8'h0E});
        end
    endtask

    task automatic test_start_during_calc();
        int dones = 0;
        int midbad = 0;
        bus8.op = 2'd0; bus8.AC = 8'h12; bus8.Memory = 8'h34; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.op = 2'd1; bus8.AC = 8'hFF; bus8.Memory = 8'h00;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bus8.done) dones++;
            if (bus8.busy && bus8.result !== 8'h0E) midbad++;
            @(posedge clk); #1;
        end
        total++;
        if (dones !== 1 || midbad !== 0) begin
            bad++; $display("FAIL ignore_start dones=%0d mid_changes=%0d exp=1/0", dones, midbad);
        end
        total++;
        if ({bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b000, 8'h46}) begin
            bad++; $display("FAIL ignore_value got=%h exp=%h",
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b000, 8'h46});
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        int dones = 0;
        run8(0, 'hFF, 'h01, lat, bc);
        bus8.op = 2'd0; bus8.AC = 8'h11; bus8.Memory = 8'h22; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== 13'h0) begin
            bad++; $display("FAIL abort_clear got=%h exp=0",
                            {bus8.busy, bus8.done, bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result});
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.done) dones++;
            @(posedge clk); #1;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL abort_no_done dones=%0d exp=0", dones);
        end
        run8(2, 'h01, 'h01, lat, bc);
        total++;
        if (lat !== 4 || {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== {3'b000, 8'h02}) begin
            bad++; $display("FAIL abort_restart lat=%0d got=%h exp=%h", lat,
                            {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, {3'b000, 8'h02});
        end
    endtask

    task automatic test_random8();
        int lat, bc, op, a, m, r, c, z, v;
        int mc = 0;
        logic [10:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = (i == 0) ? 0 : int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 255));
            m  = int'($urandom_range(0, 255));
            ref_op(8, a, m, op, mc, r, c, z, v);
            mc  = c;
            exp = {1'(c), 1'(z), 1'(v), 8'(r)};
            run8(op, a, m, lat, bc);
            total++;
            if (lat !== 4 || {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result} !== exp) begin
                bad++; $display("FAIL rand8 op=%0d a=%h m=%h lat=%0d got=%h exp=%h", op, a, m, lat,
                                {bus8.Cout, bus8.Zero, bus8.Overflow, bus8.result}, exp);
            end
        end
    endtask

    task automatic test_sweep();
        int n_exp [3] = '{16, 4, 1};
        int first [3];
        int op, a, m, r, c, z, v;
        int mc = 0;
        logic [18:0] exp;
        for (int t = 0; t < 25; t++) begin
            op = (t == 0) ? 0 : int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 65535));
            m  = int'($urandom_range(0, 65535));
            ref_op(16, a, m, op, mc, r, c, z, v);
            mc  = c;
            exp = {1'(c), 1'(z), 1'(v), 16'(r)};
            sw_op = 2'(op); sw_ac = 16'(a); sw_mem = 16'(m); sw_start = 1'b1;
            @(posedge clk); #1;
            sw_start = 1'b0;
            for (int j = 0; j < 3; j++) first[j] = -1;
            for (int k = 0; k < 19; k++) begin
                for (int j = 0; j < 3; j++)
                    if (sw_done[j] && first[j] < 0) first[j] = k;
                @(posedge clk); #1;
            end
            for (int j = 0; j < 3; j++) begin
                total++;
                if (first[j] !== n_exp[j]) begin
                    bad++; $display("FAIL sweep_latency inst=%0d got=%0d exp=%0d", j, first[j], n_exp[j]);
                end
                total++;
                if (sw_out[j] !== exp) begin
                    bad++; $display("FAIL sweep_value inst=%0d op=%0d a=%h m=%h got=%h exp=%h",
                                    j, op, a, m, sw_out[j], exp);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus8.start  = 1'b0;
        bus8.op     = 2'd0;
        bus8.AC     = 8'h00;
        bus8.Memory = 8'h00;
        sw_start    = 1'b0;
        sw_op       = 2'd0;
        sw_ac       = 16'h0;
        sw_mem      = 16'h0;
        test_reset();
        test_add();
        test_back_to_back();
        test_sub();
        test_carry_chain();
        test_start_during_calc();
        test_reset_mid_op();
        test_random8();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
